// File: rtl/hgfe_code_counter.sv
// Up/down decade counter over DIGITS BCD digits, each presented in the 4-bit HGFE code.
// Optional feature: define HGFE_SATURATE_EN to saturate at all-9 / all-0 instead of wrapping.
module hgfe_code_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_bcd,
  output logic [4*DIGITS-1:0]   code,
  output logic                  tc,
  output logic                  load_err
);

  function automatic logic [3:0] bcd_to_hgfe(input logic [3:0] bcd);
    logic [3:0] hgfe;
    case (bcd)
      4'd0:    hgfe = 4'b0000;
      4'd1:    hgfe = 4'b0001;
      4'd2:    hgfe = 4'b0011;
      4'd3:    hgfe = 4'b0100;
      4'd4:    hgfe = 4'b0101;
      4'd5:    hgfe = 4'b0111;
      4'd6:    hgfe = 4'b1001;
      4'd7:    hgfe = 4'b1011;
      4'd8:    hgfe = 4'b1100;
      4'd9:    hgfe = 4'b1101;
      default: hgfe = 4'b0000;
    endcase
    return hgfe;
  endfunction

  logic [4*DIGITS-1:0] state_reg;
  logic [4*DIGITS-1:0] state_next;
  logic [4*DIGITS-1:0] step_value;
  logic [DIGITS-1:0]   at_limit;
  logic [DIGITS-1:0]   bad_nibble;
  logic [DIGITS:0]     step_chain;
  logic                load_bad;
  logic                all_limit;
  logic                count_go;
  logic                load_err_reg;

  // step_chain[i] is high when every digit below i sits at its limit (ripple enable).
  assign step_chain[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      logic [3:0] digit_inc;
      logic [3:0] digit_dec;

      assign digit      = state_reg[4*gi +: 4];
      assign digit_inc  = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
      assign digit_dec  = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
      assign at_limit[gi]   = up ? (digit == 4'd9) : (digit == 4'd0);
      assign step_chain[gi+1] = step_chain[gi] & at_limit[gi];
      assign bad_nibble[gi] = (load_bcd[4*gi +: 4] > 4'd9);
      assign step_value[4*gi +: 4] = step_chain[gi] ? (up ? digit_inc : digit_dec) : digit;
      assign code[4*gi +: 4] = bcd_to_hgfe(digit);
    end
  endgenerate

  assign load_bad  = |bad_nibble;
  assign all_limit = step_chain[DIGITS];
  assign tc        = en & ~load & all_limit;

`ifdef HGFE_SATURATE_EN
  assign count_go = en & ~load & ~all_limit;
`else
  assign count_go = en & ~load;
`endif

  always_comb begin
    state_next = state_reg;
    if (load) begin
      if (!load_bad) state_next = load_bcd;
    end else if (count_go) begin
      state_next = step_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= '0;
      load_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      load_err_reg <= load & load_bad;
    end
  end

  assign load_err = load_err_reg;

endmodule

// File: tb/tb_hgfe_code_counter.sv
// Directed bench for hgfe_code_counter (DIGITS=2): vector table plus count/loop-back sequences.
module tb_hgfe_code_counter;

  localparam int DIGITS = 2;
`ifdef HGFE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_bcd = 8'h00;
  logic [7:0] code;
  logic       tc;
  logic       load_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hgfe_code_counter #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_bcd (load_bcd),
    .code     (code),
    .tc       (tc),
    .load_err (load_err)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] bcd;
    logic       exp_tc;
    logic [7:0] exp_code;
    logic       exp_err;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic r, input logic e, input logic u, input logic l,
                              input logic [7:0] b, input logic t, input logic [7:0] c,
                              input logic er);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.load = l; v.bcd = b;
    v.exp_tc = t; v.exp_code = c; v.exp_err = er;
    return v;
  endfunction

  // Downstream HGFE->DCBA decoder; 4'hF flags an illegal code.
  function automatic logic [3:0] hgfe_to_bcd(input logic [3:0] h);
    case (h)
      4'b0000: return 4'd0;
      4'b0001: return 4'd1;
      4'b0011: return 4'd2;
      4'b0100: return 4'd3;
      4'b0101: return 4'd4;
      4'b0111: return 4'd5;
      4'b1001: return 4'd6;
      4'b1011: return 4'd7;
      4'b1100: return 4'd8;
      4'b1101: return 4'd9;
      default: return 4'hF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  initial begin
    int t_dec, o_dec, val, ref_val;

    vecs[0]  = mk(1,1,1,1,8'h55, 0, 8'b0000_0000, 0);
    vecs[1]  = mk(1,1,1,1,8'h55, 0, 8'b0000_0000, 0);
    vecs[2]  = mk(0,0,1,0,8'h00, 0, 8'b0000_0000, 0);
    vecs[3]  = mk(0,0,1,1,8'h47, 0, 8'b0101_1011, 0);
    vecs[4]  = mk(0,0,1,1,8'h4A, 0, 8'b0101_1011, 1);
    vecs[5]  = mk(0,0,1,0,8'h00, 0, 8'b0101_1011, 0);
    vecs[6]  = mk(0,1,1,1,8'h30, 0, 8'b0100_0000, 0);
    vecs[7]  = mk(0,1,1,0,8'h00, 0, 8'b0100_0001, 0);
    vecs[8]  = mk(0,1,0,0,8'h00, 0, 8'b0100_0000, 0);
    vecs[9]  = mk(0,1,0,0,8'h00, 0, 8'b0011_1101, 0);
    vecs[10] = mk(0,0,1,1,8'h99, 0, 8'b1101_1101, 0);
    vecs[11] = mk(0,1,1,0,8'h00, 1, SAT ? 8'b1101_1101 : 8'b0000_0000, 0);
    vecs[12] = mk(0,0,1,1,8'h00, 0, 8'b0000_0000, 0);
    vecs[13] = mk(0,1,0,0,8'h00, 1, SAT ? 8'b0000_0000 : 8'b1101_1101, 0);
    vecs[14] = mk(0,1,0,0,8'h00, SAT, SAT ? 8'b0000_0000 : 8'b1101_1100, 0);
    vecs[15] = mk(0,0,1,1,8'h09, 0, 8'b0000_1101, 0);
    vecs[16] = mk(0,1,1,0,8'h00, 0, 8'b0001_0000, 0);
    vecs[17] = mk(1,1,1,0,8'h00, 0, 8'b0000_0000, 0);
    vecs[18] = mk(1,0,1,1,8'hA0, 0, 8'b0000_0000, 0);
    vecs[19] = mk(0,0,1,1,8'h9A, 0, 8'b0000_0000, 1);
    vecs[20] = mk(0,0,1,1,8'h12, 0, 8'b0001_0011, 0);

    @(posedge clk); #1;

    for (int i = 0; i < 21; i++) begin
      rst = vecs[i].rst; en = vecs[i].en; up = vecs[i].up;
      load = vecs[i].load; load_bcd = vecs[i].bcd;
      #1;
      check($sformatf("vec%0d_tc", i), {31'b0, tc}, {31'b0, vecs[i].exp_tc});
      @(posedge clk); #1;
      check($sformatf("vec%0d_code", i), {24'b0, code}, {24'b0, vecs[i].exp_code});
      check($sformatf("vec%0d_load_err", i), {31'b0, load_err}, {31'b0, vecs[i].exp_err});
      $display("vec %0d: rst=%0b en=%0b up=%0b load=%0b bcd=%h -> code=%b tc_pre=%0b load_err=%0b",
               i, vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].bcd,
               code, vecs[i].exp_tc, load_err);
    end

    // Up count from reset over every value, decoding each digit downstream.
    rst = 1'b1; en = 1'b0; load = 1'b0; up = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1;
    for (int n = 0; n <= 101; n++) begin
      ref_val = SAT ? ((n > 99) ? 99 : n) : (n % 100);
      t_dec = int'(hgfe_to_bcd(code[7:4]));
      o_dec = int'(hgfe_to_bcd(code[3:0]));
      val = t_dec * 10 + o_dec;
      check($sformatf("legal_code_n%0d", n), {31'b0, (t_dec != 15 && o_dec != 15)}, 32'd1);
      check($sformatf("decoded_n%0d", n), val, ref_val);
      if (n == 10)  check("code_after_10", {24'b0, code}, {24'b0, 8'b0001_0000});
      if (n == 99) begin
        check("code_after_99", {24'b0, code}, {24'b0, 8'b1101_1101});
        check("tc_at_99", {31'b0, tc}, 32'd1);
      end
      if (n == 100) check("code_after_wrap", {24'b0, code},
                          {24'b0, SAT ? 8'b1101_1101 : 8'b0000_0000});
      $display("count n=%0d: code=%b decoded=%0d ref=%0d tc=%0b", n, code, val, ref_val, tc);
      @(posedge clk); #1;
    end

    // Direction change in the same cycle as a load: load wins, then down steps from loaded value.
    en = 1'b1; up = 1'b0; load = 1'b1; load_bcd = 8'h10;
    @(posedge clk); #1;
    check("dir_load_code", {24'b0, code}, {24'b0, 8'b0001_0000});
    load = 1'b0;
    @(posedge clk); #1;
    check("borrow_code", {24'b0, code}, {24'b0, 8'b0000_1101});
    $display("borrow seq: code=%b", code);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
